// File: rtl/vecmac_pkg.sv
// Shared defaults, FSM state type and lane-slicing helpers for the
// multi-lane vector accumulator.
package vecmac_pkg;

    localparam int DEF_W_IN      = 18;
    localparam int DEF_W_ACC     = 26;
    localparam int DEF_LANES     = 4;
    localparam int DEF_MAX_BEATS = 1024;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // LSB position of lane 'lane' inside a bus of 'width'-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    // MSB position of lane 'lane' inside a bus of 'width'-bit lanes.
    function automatic int lane_msb(input int lane, input int width);
        return lane * width + width - 1;
    endfunction

endpackage

// File: rtl/vec_accumulator_mc_acc_lane.sv
// One accumulator lane: operand extension, add, overflow detection,
// optional saturation, plus the running sum and sticky overflow flag.
module acc_lane
    import vecmac_pkg::*;
#(
    parameter int W_IN     = DEF_W_IN,
    parameter int W_ACC    = DEF_W_ACC,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [W_IN-1:0]  i_data,
    output logic [W_ACC-1:0] o_sum_next,
    output logic             o_ovf_next
);

    logic [W_ACC-1:0] r_sum;
    logic             r_ovf;

    logic [W_ACC-1:0] w_ext;
    logic [W_ACC-1:0] w_raw;
    logic [W_ACC-1:0] w_sat_val;
    logic             w_carry;
    logic             w_ovf_now;

    always_comb begin
        if (SIGNED != 0) begin
            w_ext = W_ACC'($signed(i_data));
        end else begin
            w_ext = W_ACC'(i_data);
        end
    end

    assign {w_carry, w_raw} = {1'b0, r_sum} + {1'b0, w_ext};

    // Signed overflow only happens when both operands share a sign, so the
    // clamp direction follows the running sum's sign.
    always_comb begin
        w_ovf_now = 1'b0;
        w_sat_val = '1;
        if (SIGNED != 0) begin
            w_ovf_now = (r_sum[W_ACC-1] == w_ext[W_ACC-1]) &&
                        (w_raw[W_ACC-1] != r_sum[W_ACC-1]);
            w_sat_val = r_sum[W_ACC-1] ? {1'b1, {(W_ACC-1){1'b0}}}
                                       : {1'b0, {(W_ACC-1){1'b1}}};
        end else begin
            w_ovf_now = w_carry;
            w_sat_val = '1;
        end
    end

    assign o_sum_next = ((SATURATE != 0) && w_ovf_now) ? w_sat_val : w_raw;
    assign o_ovf_next = r_ovf | w_ovf_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else if (i_clear) begin
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else if (i_load) begin
            r_sum <= o_sum_next;
            r_ovf <= o_ovf_next;
        end
    end

endmodule

// File: rtl/vec_accumulator_mc.sv
// Multi-lane vector accumulator: sums a configurable number of beats per lane
// and presents all lane results on a one-deep valid/ready output register.
module vec_accumulator_mc
    import vecmac_pkg::*;
#(
    parameter int W_IN      = DEF_W_IN,
    parameter int W_ACC     = DEF_W_ACC,
    parameter int LANES     = DEF_LANES,
    parameter int MAX_BEATS = DEF_MAX_BEATS,
    parameter int SIGNED    = 0,
    parameter int SATURATE  = 0,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CNT_W-1:0]       cfg_beats,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*W_IN-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*W_ACC-1:0] out_data,
    output logic [LANES-1:0]       out_ovf,
    output logic                   busy
);

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       r_beats;
    logic [CNT_W-1:0]       w_cfg_eff;
    logic [CNT_W-1:0]       w_beats;
    logic                   w_is_last;
    logic                   w_accept;
    logic                   w_done;

    logic                   r_out_valid;
    logic [LANES*W_ACC-1:0] r_out_data;
    logic [LANES-1:0]       r_out_ovf;
    logic [LANES*W_ACC-1:0] w_sum_next_all;
    logic [LANES-1:0]       w_ovf_next_all;

    // Out-of-range beat counts are folded into the legal 1..MAX_BEATS range.
    always_comb begin
        w_cfg_eff = cfg_beats;
        if (cfg_beats == '0) begin
            w_cfg_eff = CNT_W'(1);
        end else if (cfg_beats > CNT_W'(MAX_BEATS)) begin
            w_cfg_eff = CNT_W'(MAX_BEATS);
        end
    end

    // cfg_beats is only honoured on the first beat; afterwards the latched copy rules.
    assign w_beats   = (r_state == IDLE) ? w_cfg_eff : r_beats;
    assign w_is_last = (r_count == (w_beats - CNT_W'(1)));

    // A stalled result only blocks the beat that would overwrite it.
    assign in_ready  = !clr && !(r_out_valid && !out_ready && w_is_last);
    assign w_accept  = in_valid && in_ready;
    assign w_done    = w_accept && w_is_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = IDLE;
        end else if (w_accept) begin
            w_state_next = w_is_last ? IDLE : ACC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_beats <= '0;
        end else begin
            if (clr || w_done) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_accept && (r_state == IDLE)) begin
                r_beats <= w_cfg_eff;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= '0;
        end else if (w_done) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sum_next_all;
            r_out_ovf   <= w_ovf_next_all;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            acc_lane #(
                .W_IN     (W_IN),
                .W_ACC    (W_ACC),
                .SIGNED   (SIGNED),
                .SATURATE (SATURATE)
            ) u_lane (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_clear    (clr || w_done),
                .i_load     (w_accept && !w_is_last),
                .i_data     (in_data[lane_lsb(gi, W_IN) +: W_IN]),
                .o_sum_next (w_sum_next_all[lane_lsb(gi, W_ACC) +: W_ACC]),
                .o_ovf_next (w_ovf_next_all[gi])
            );
        end
    endgenerate

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;
    assign busy      = (r_state == ACC);

endmodule

// File: tb/tb_vec_accumulator_mc.sv
// Randomized and directed bench for vec_accumulator_mc: one unsigned/wrap
// instance and two 8-bit signed instances (saturate and wrap) share control.
module tb_vec_accumulator_mc;

    localparam int LANES = 4;
    localparam int CNT_W = 11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CNT_W-1:0]  cfg_beats = '0;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [71:0]       in_data = '0;
    logic [31:0]       in_data_s = '0;

    logic [2:0]        rdy;
    logic [2:0]        vld;
    logic [2:0]        bsy;
    logic [103:0]      od0;
    logic [31:0]       od1;
    logic [31:0]       od2;
    logic [3:0]        ov0;
    logic [3:0]        ov1;
    logic [3:0]        ov2;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Behavioural model state: k=0 unsigned 26-bit wrap, k=1 signed 8-bit sat, k=2 signed 8-bit wrap.
    longint m_sum[3][4];
    bit     m_ovf[3][4];
    longint m_out_sum[3][4];
    bit     m_out_ovf[3][4];
    int     m_count;
    int     m_beats;
    bit     m_out_valid;

    vec_accumulator_mc dut0 (
        .clk(clk), .rst_n(rst_n), .cfg_beats(cfg_beats), .clr(clr),
        .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
        .out_valid(vld[0]), .out_ready(out_ready), .out_data(od0),
        .out_ovf(ov0), .busy(bsy[0])
    );

    vec_accumulator_mc #(.W_IN(8), .W_ACC(8), .SIGNED(1), .SATURATE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_beats(cfg_beats), .clr(clr),
        .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data_s),
        .out_valid(vld[1]), .out_ready(out_ready), .out_data(od1),
        .out_ovf(ov1), .busy(bsy[1])
    );

    vec_accumulator_mc #(.W_IN(8), .W_ACC(8), .SIGNED(1), .SATURATE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .cfg_beats(cfg_beats), .clr(clr),
        .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data_s),
        .out_valid(vld[2]), .out_ready(out_ready), .out_data(od2),
        .out_ovf(ov2), .busy(bsy[2])
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic longint lane_mask(input int k);
        return (k == 0) ? ((longint'(1) << 26) - 1) : 64'hFF;
    endfunction

    function automatic int eff_beats(input logic [CNT_W-1:0] cb);
        if (cb == 0) return 1;
        if (cb > 1024) return 1024;
        return int'(cb);
    endfunction

    function automatic longint lane_in(input int k, input int i, input logic [71:0] d, input logic [31:0] ds);
        logic [17:0] u;
        logic [7:0]  s;
        u = d[i*18 +: 18];
        s = ds[i*8 +: 8];
        if (k == 0) return longint'(u);
        return longint'($signed(s));
    endfunction

    // Plain integer add, then range check against the lane's representable range.
    function automatic longint model_add(input longint a, input longint b, input int k, output bit ov);
        longint lo, hi, s;
        lo = (k == 0) ? 0 : -128;
        hi = (k == 0) ? ((longint'(1) << 26) - 1) : 127;
        s  = a + b;
        ov = 1'b0;
        if (s > hi || s < lo) begin
            ov = 1'b1;
            if (k == 1)      s = (s > hi) ? hi : lo;
            else if (k == 0) s = s - (longint'(1) << 26);
            else             s = (s > hi) ? s - 256 : s + 256;
        end
        return s;
    endfunction

    function automatic void clear_partial();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < LANES; i++) begin
                m_sum[k][i] = 0;
                m_ovf[k][i] = 1'b0;
            end
        m_count = 0;
    endfunction

    function automatic void model_reset();
        clear_partial();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < LANES; i++) begin
                m_out_sum[k][i] = 0;
                m_out_ovf[k][i] = 1'b0;
            end
        m_beats     = 0;
        m_out_valid = 1'b0;
    endfunction

    function automatic bit model_ready(input bit c, input bit ordy, input logic [CNT_W-1:0] cb);
        int beats;
        bit last;
        beats = (m_count == 0) ? eff_beats(cb) : m_beats;
        last  = (m_count == beats - 1);
        return !c && !(m_out_valid && !ordy && last);
    endfunction

    function automatic void model_step(input bit acc, input bit c, input bit ordy,
                                       input logic [CNT_W-1:0] cb, input logic [71:0] d,
                                       input logic [31:0] ds);
        bit done;
        bit ov;
        done = 1'b0;
        if (acc) begin
            if (m_count == 0) m_beats = eff_beats(cb);
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < LANES; i++) begin
                    m_sum[k][i] = model_add(m_sum[k][i], lane_in(k, i, d, ds), k, ov);
                    m_ovf[k][i] = m_ovf[k][i] | ov;
                end
            m_count++;
            done = (m_count == m_beats);
        end
        if (done) begin
            m_out_valid = 1'b1;
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < LANES; i++) begin
                    m_out_sum[k][i] = m_sum[k][i];
                    m_out_ovf[k][i] = m_ovf[k][i];
                end
            n_txn++;
            $display("TXN %0d beats=%0d u=%0d,%0d,%0d,%0d s_sat=%0d s_wrap=%0d",
                     n_txn, m_beats, m_sum[0][0], m_sum[0][1], m_sum[0][2], m_sum[0][3],
                     m_sum[1][0], m_sum[2][0]);
            clear_partial();
        end else if (m_out_valid && ordy) begin
            m_out_valid = 1'b0;
        end
        if (c) clear_partial();
    endfunction

    function automatic logic [63:0] dut_lane(input int k, input int i);
        if (k == 0) return 64'(od0[i*26 +: 26]);
        if (k == 1) return 64'(od1[i*8 +: 8]);
        return 64'(od2[i*8 +: 8]);
    endfunction

    function automatic logic dut_ovf(input int k, input int i);
        if (k == 0) return ov0[i];
        if (k == 1) return ov1[i];
        return ov2[i];
    endfunction

    task automatic check_outputs();
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("out_valid%0d", k), 64'(vld[k]), 64'(m_out_valid));
            check_eq($sformatf("busy%0d", k), 64'(bsy[k]), 64'(m_count != 0));
        end
        if (m_out_valid) begin
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < LANES; i++) begin
                    check_eq($sformatf("data%0d_lane%0d", k, i), dut_lane(k, i),
                             64'(m_out_sum[k][i] & lane_mask(k)));
                    check_eq($sformatf("ovf%0d_lane%0d", k, i), 64'(dut_ovf(k, i)),
                             64'(m_out_ovf[k][i]));
                end
        end
    endtask

    // Starts and ends on a falling edge; inputs held across the rising edge.
    task automatic cycle(input bit v, input logic [71:0] d, input logic [31:0] ds,
                         input logic [CNT_W-1:0] cb, input bit c, input bit ordy, output bit acc);
        bit rdy_exp;
        in_valid  = v;
        in_data   = d;
        in_data_s = ds;
        cfg_beats = cb;
        clr       = c;
        out_ready = ordy;
        #1;
        rdy_exp = model_ready(c, ordy, cb);
        for (int k = 0; k < 3; k++)
            check_eq($sformatf("in_ready%0d", k), 64'(rdy[k]), 64'(rdy_exp));
        acc = v && rdy_exp;
        @(posedge clk);
        model_step(acc, c, ordy, cb, d, ds);
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [71:0] fill_u(input int v);
        logic [71:0] d;
        d = '0;
        for (int i = 0; i < LANES; i++) d[i*18 +: 18] = 18'(v);
        return d;
    endfunction

    function automatic logic [31:0] fill_s(input int v);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < LANES; i++) d[i*8 +: 8] = 8'(v);
        return d;
    endfunction

    initial begin
        bit          a;
        int          sent;
        logic [71:0] d;
        logic [31:0] ds;

        model_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("rst_valid%0d", k), 64'(vld[k]), 64'(0));
            check_eq($sformatf("rst_busy%0d", k), 64'(bsy[k]), 64'(0));
        end
        check_eq("rst_data0", 64'(od0 != '0), 64'(0));
        check_eq("rst_ovf0", 64'(ov0), 64'(0));
        rst_n = 1'b1;

        // Lane i carries i+1 for 250 beats.
        d = '0;
        for (int i = 0; i < LANES; i++) d[i*18 +: 18] = 18'(i + 1);
        ds = fill_s(1);
        for (int n = 0; n < 250; n++) cycle(1'b1, d, ds, 11'd250, 1'b0, 1'b1, a);
        check_eq("t1_lane0", 64'(od0[0 +: 26]), 64'd250);
        check_eq("t1_lane1", 64'(od0[26 +: 26]), 64'd500);
        check_eq("t1_lane2", 64'(od0[52 +: 26]), 64'd750);
        check_eq("t1_lane3", 64'(od0[78 +: 26]), 64'd1000);
        check_eq("t1_ovf", 64'(ov0), 64'd0);
        cycle(1'b0, '0, '0, 11'd0, 1'b0, 1'b1, a);

        // One-beat vectors back to back.
        repeat (5) cycle(1'b1, fill_u(7), fill_s(7), 11'd1, 1'b0, 1'b1, a);
        cycle(1'b0, '0, '0, 11'd1, 1'b0, 1'b1, a);

        // Stalled result while a 3-beat vector streams in.
        cycle(1'b1, fill_u(3), fill_s(3), 11'd2, 1'b0, 1'b1, a);
        cycle(1'b1, fill_u(3), fill_s(3), 11'd2, 1'b0, 1'b0, a);
        sent = 0;
        for (int n = 0; n < 20; n++) begin
            cycle(sent < 3, fill_u(5 + sent), fill_s(5 + sent), 11'd3, 1'b0, 1'b0, a);
            if (a) sent++;
        end
        check_eq("stall_accepted", 64'(sent), 64'd2);
        for (int n = 0; n < 5 && sent < 3; n++) begin
            cycle(1'b1, fill_u(5 + sent), fill_s(5 + sent), 11'd3, 1'b0, 1'b1, a);
            if (a) sent++;
        end
        check_eq("stall_result2", 64'(od0[0 +: 26]), 64'd18);
        cycle(1'b0, '0, '0, 11'd3, 1'b0, 1'b1, a);

        // Signed overflow: +100 x3 then -100 x3.
        repeat (3) cycle(1'b1, fill_u(1), fill_s(100), 11'd3, 1'b0, 1'b1, a);
        check_eq("sat_pos", 64'(od1[7:0]), 64'd127);
        check_eq("wrap_pos", 64'(od2[7:0]), 64'd44);
        check_eq("sat_pos_ovf", 64'(ov1[0]), 64'd1);
        check_eq("wrap_pos_ovf", 64'(ov2[0]), 64'd1);
        repeat (3) cycle(1'b1, fill_u(1), fill_s(-100), 11'd3, 1'b0, 1'b1, a);
        check_eq("sat_neg", 64'(od1[7:0]), 64'h80);
        check_eq("wrap_neg", 64'(od2[7:0]), 64'hD4);
        cycle(1'b0, '0, '0, 11'd3, 1'b0, 1'b1, a);

        // Soft clear mid-vector with a beat offered alongside it.
        repeat (10) cycle(1'b1, fill_u(1), fill_s(1), 11'd250, 1'b0, 1'b1, a);
        cycle(1'b1, fill_u(1), fill_s(1), 11'd250, 1'b1, 1'b1, a);
        check_eq("clr_dropped", 64'(a), 64'd0);
        repeat (250) cycle(1'b1, fill_u(1), fill_s(1), 11'd250, 1'b0, 1'b1, a);
        check_eq("clr_result", 64'(od0[0 +: 26]), 64'd250);
        cycle(1'b0, '0, '0, 11'd1, 1'b0, 1'b1, a);

        // Oversized beat count clamps to 1024; full-scale data overflows lane sums.
        for (int n = 0; n < 1024; n++) begin
            d  = {$urandom, $urandom, $urandom};
            ds = $urandom;
            cycle(1'b1, d, ds, 11'd2000, 1'b0, 1'b1, a);
        end
        cycle(1'b0, '0, '0, 11'd1, 1'b0, 1'b1, a);

        // Random traffic: mid-vector cfg changes, bubbles, back-pressure, clears.
        for (int n = 0; n < 3000; n++) begin
            d  = {$urandom, $urandom, $urandom};
            ds = $urandom;
            cycle($urandom_range(0, 3) != 0, d, ds, 11'($urandom_range(0, 6)),
                  $urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, a);
        end

        // Async reset mid-vector while a result is pending.
        repeat (2) cycle(1'b0, '0, '0, 11'd1, 1'b0, 1'b1, a);
        cycle(1'b1, fill_u(2), fill_s(2), 11'd2, 1'b0, 1'b1, a);
        cycle(1'b1, fill_u(2), fill_s(2), 11'd2, 1'b0, 1'b0, a);
        repeat (2) cycle(1'b1, fill_u(4), fill_s(4), 11'd5, 1'b0, 1'b0, a);
        check_eq("pre_rst_valid", 64'(vld[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("arst_valid%0d", k), 64'(vld[k]), 64'd0);
            check_eq($sformatf("arst_busy%0d", k), 64'(bsy[k]), 64'd0);
        end
        check_eq("arst_data0", 64'(od0 != '0), 64'd0);
        check_eq("arst_data1", 64'(od1), 64'd0);
        check_eq("arst_ovf0", 64'(ov0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cycle(1'b1, fill_u(9), fill_s(9), 11'd4, 1'b0, 1'b1, a);
        check_eq("post_rst_result", 64'(od0[0 +: 26]), 64'd36);
        cycle(1'b0, '0, '0, 11'd4, 1'b0, 1'b1, a);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
